conv_1x1_stream: RTL and testbench
==================================

// Module: conv_1x1_stream
// PURPOSE
//  Streaming pointwise (1x1) convolution. Accepts one pixel (all IN_CHANNELS) per valid/ready beat.
//  Produces OUT_CHANNELS requantised outputs in groups of PAR_OUT, with per-channel bias, rounding
//  shift and saturation. Sits between feature-map streaming stages; weights and bias are preloaded.
//  Generalises the buffered 1x1 conv: adds backpressure, bias, requant, output parallelism, runtime pixel count.
// PARAMETERS
//  DATA_WIDTH    8    signed width of activations, weights and outputs
//  IN_CHANNELS   16   input channels per pixel
//  OUT_CHANNELS  32   output channels; must be a multiple of PAR_OUT
//  PAR_OUT       4    output channels computed per group (parallel MAC lanes)
//  ACC_WIDTH     24   accumulator width; >= 2*DATA_WIDTH+$clog2(IN_CHANNELS)+1
//  BIAS_WIDTH    16   signed bias width; <= ACC_WIDTH
//  MAX_PIXELS    784  maximum pixels per run
// PORTS
//  clk           in   1                          clock
//  rst           in   1                          synchronous reset, active-high
//  start         in   1                          begin run; sampled only in IDLE
//  cfg_num_pixels in  $clog2(MAX_PIXELS+1)       pixels in this run; latched at start
//  cfg_shift     in   5                          requant right shift; latched at start
//  busy          out  1                          high from cycle after start until done
//  done          out  1                          1-cycle pulse at end of run
//  wt_wr_en      in   1                          weight write strobe
//  wt_wr_addr    in   $clog2(IN_CHANNELS*OUT_CHANNELS)  addr = oc*IN_CHANNELS+ic
//  wt_wr_data    in   DATA_WIDTH                 signed weight
//  bias_wr_en    in   1                          bias write strobe
//  bias_wr_addr  in   $clog2(OUT_CHANNELS)       output channel index
//  bias_wr_data  in   BIAS_WIDTH                 signed bias
//  in_valid/in_ready  in/out  1                  pixel handshake
//  in_data       in   DATA_WIDTH*IN_CHANNELS     channel ic at bits [ic*DATA_WIDTH +: DATA_WIDTH]
//  out_valid/out_ready out/in 1                  group handshake
//  out_data      out  DATA_WIDTH*PAR_OUT         lane l = channel group*PAR_OUT+l
//  out_group     out  $clog2(OUT_CHANNELS/PAR_OUT) group index of out_data
//  out_last      out  1                          last group of last pixel
// BEHAVIOUR
//  Reset: state IDLE; busy, done, in_ready, out_valid, out_last = 0; out_data, out_group = 0.
//   Weight/bias RAM contents are not cleared.
//  FSM:
//   IDLE  -> FETCH on start (-> DONE directly if cfg_num_pixels==0).
//   FETCH: in_ready=1; latch pixel on in_valid&&in_ready -> MAC, group=0.
//   MAC: 1 cycle weight/bias RAM read, 2-stage adder tree -> REQ.
//   REQ: 1 cycle requant; out_valid rises next cycle -> OUT.
//   OUT: hold out_* stable until out_ready. On handshake:
//    next group -> MAC; else next pixel -> FETCH; else -> DONE.
//   DONE: done=1 for one cycle -> IDLE.
//  Latency: out_valid rises 4 cycles after pixel handshake (group 0), or after previous out handshake (group g>0).
//  in_ready is high only in FETCH; never high while out_valid.
//  Arithmetic, per lane:
//   acc = sum(signed in*w) in ACC_WIDTH, + sign-extended bias;
//   if shift>0 add 1<<(shift-1) (round half up), then arithmetic >> shift;
//   saturate to [-2^(DW-1), 2^(DW-1)-1].
//  Boundaries:
//   - start while busy: ignored.
//   - wt/bias writes while busy: ignored; out-of-range write addresses: ignored.
//   - cfg_num_pixels > MAX_PIXELS: clamped to MAX_PIXELS.
//   - rst mid-run: immediate return to IDLE; no done pulse; in-flight data dropped.
//   - out_last asserted with out_valid only on final group of final pixel.
// CONFIGURATION
//  CONV1X1_RELU_EN defined: after saturation, negative lane results forced to 0.
//  Not defined: signed saturated results passed through unchanged.
// STRUCTURE
//  Package conv1x1_pkg: state enum (IDLE,FETCH,MAC,REQ,OUT,DONE), sat/round function, ACC width check.
//  Sub-module conv1x1_lane: one output channel's MAC tree + bias + requant (+ReLU); instantiated PAR_OUT times.
// TESTING
//  1. all in=1, all w=1, bias=0, shift=0, 1 pixel -> 8 groups of lanes = 16, out_last on group 7, done pulse.
//  2. in=127, w=127, 16 ch, shift=0 -> every lane saturates to 127; w=-128 gives -128 (0 with CONV1X1_RELU_EN).
//  3. acc=6, bias=0, shift=2 -> 2 (round half up, 1.5->2); acc=5 -> 1; bias=-10 with acc=6, shift=0 -> -4.
//  4. 3 pixels, out_ready toggled 1-in-3 -> out_data stable while stalled, 24 groups in order, no loss.
//  5. cfg_num_pixels=0 -> done pulse 2 cycles after start, in_ready never high.
//  6. rst asserted in MAC of pixel 2 -> next cycle IDLE, all outputs 0; rerun reuses preloaded weights.

Source files
------------

// File: rtl/conv1x1_pkg.sv
// Shared FSM state type and requantisation helpers for the 1x1 streaming convolution.
// Optional ReLU on lane results: define CONV1X1_RELU_EN.
package conv1x1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        REQ,
        OUT,
        DONE
    } state_t;

    // weight read + two adder-tree stages
    localparam int MAC_CYCLES = 3;

    function automatic bit acc_width_ok(int dw, int ic, int aw);
        return aw >= 2 * dw + $clog2(ic) + 1;
    endfunction

    // Round half up, arithmetic shift, clamp to a signed dw-bit range.
    function automatic int requant(longint acc, logic [4:0] sh, int dw);
        longint r;
        longint hi;
        longint lo;
        r = acc;
        if (sh != 5'd0) begin
            r = r + (longint'(1) << (sh - 5'd1));
        end
        r = r >>> sh;
        hi = (longint'(1) << (dw - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return int'(r);
    endfunction

endpackage

// File: rtl/conv1x1_lane.sv
// One output channel: multiply-accumulate tree, bias, requantisation, saturation.
// Negative results are clamped to zero when CONV1X1_RELU_EN is defined.
module conv1x1_lane
    import conv1x1_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_CHANNELS = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int BIAS_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH*IN_CHANNELS-1:0] pix,
    input  logic [DATA_WIDTH*IN_CHANNELS-1:0] wts,
    input  logic signed [BIAS_WIDTH-1:0]      bias,
    input  logic [4:0]                        shift,
    input  logic                              req_en,
    output logic [DATA_WIDTH-1:0]             res
);

    localparam int HALF = IN_CHANNELS / 2;

    logic signed [ACC_WIDTH-1:0] sum_lo_d;
    logic signed [ACC_WIDTH-1:0] sum_hi_d;
    logic signed [ACC_WIDTH-1:0] sum_lo_q;
    logic signed [ACC_WIDTH-1:0] sum_hi_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0]       res_d;
    int                          rq;

    always_comb begin
        sum_lo_d = '0;
        sum_hi_d = '0;
        for (int i = 0; i < IN_CHANNELS; i++) begin
            if (i < HALF) begin
                sum_lo_d = sum_lo_d
                    + ACC_WIDTH'($signed(pix[i*DATA_WIDTH +: DATA_WIDTH]))
                    * ACC_WIDTH'($signed(wts[i*DATA_WIDTH +: DATA_WIDTH]));
            end else begin
                sum_hi_d = sum_hi_d
                    + ACC_WIDTH'($signed(pix[i*DATA_WIDTH +: DATA_WIDTH]))
                    * ACC_WIDTH'($signed(wts[i*DATA_WIDTH +: DATA_WIDTH]));
            end
        end
    end

    always_comb begin
        rq    = requant(longint'(acc_q), shift, DATA_WIDTH);
        res_d = rq[DATA_WIDTH-1:0];
`ifdef CONV1X1_RELU_EN
        if (rq < 0) begin
            res_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_lo_q <= '0;
            sum_hi_q <= '0;
            acc_q    <= '0;
            res      <= '0;
        end else begin
            sum_lo_q <= sum_lo_d;
            sum_hi_q <= sum_hi_d;
            acc_q    <= sum_lo_q + sum_hi_q + ACC_WIDTH'(bias);
            if (req_en) begin
                res <= res_d;
            end
        end
    end

endmodule

// File: rtl/conv_1x1_stream.sv
// Streaming pointwise convolution: one pixel in, OUT_CHANNELS/PAR_OUT output groups out.
// Build with CONV1X1_RELU_EN defined to zero negative outputs.
module conv_1x1_stream
    import conv1x1_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IN_CHANNELS  = 16,
    parameter int OUT_CHANNELS = 32,
    parameter int PAR_OUT      = 4,
    parameter int ACC_WIDTH    = 24,
    parameter int BIAS_WIDTH   = 16,
    parameter int MAX_PIXELS   = 784
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [$clog2(MAX_PIXELS+1)-1:0]              cfg_num_pixels,
    input  logic [4:0]                                   cfg_shift,
    output logic                                         busy,
    output logic                                         done,
    input  logic                                         wt_wr_en,
    input  logic [$clog2(IN_CHANNELS*OUT_CHANNELS)-1:0]  wt_wr_addr,
    input  logic [DATA_WIDTH-1:0]                        wt_wr_data,
    input  logic                                         bias_wr_en,
    input  logic [$clog2(OUT_CHANNELS)-1:0]              bias_wr_addr,
    input  logic [BIAS_WIDTH-1:0]                        bias_wr_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_WIDTH*IN_CHANNELS-1:0]            in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DATA_WIDTH*PAR_OUT-1:0]                out_data,
    output logic [$clog2(OUT_CHANNELS/PAR_OUT)-1:0]      out_group,
    output logic                                         out_last
);

    localparam int NG  = OUT_CHANNELS / PAR_OUT;
    localparam int PW  = $clog2(MAX_PIXELS + 1);
    localparam int NW  = IN_CHANNELS * OUT_CHANNELS;
    localparam int WAW = $clog2(NW);
    localparam int BAW = $clog2(OUT_CHANNELS);
    localparam int GW  = $clog2(NG);
    localparam int LW  = DATA_WIDTH * IN_CHANNELS;

    if (!acc_width_ok(DATA_WIDTH, IN_CHANNELS, ACC_WIDTH)) begin : g_bad_acc
        $error("ACC_WIDTH too narrow for DATA_WIDTH and IN_CHANNELS");
    end

    state_t                state;
    state_t                state_n;
    logic [1:0]            ph;
    logic [GW-1:0]         grp;
    logic [PW-1:0]         npix;
    logic [PW-1:0]         pix_cnt;
    logic [PW-1:0]         cfg_clamped;
    logic [4:0]            shift_q;
    logic [LW-1:0]         pix_q;
    logic                  last_grp;
    logic                  last_pix;
    logic [DATA_WIDTH-1:0] wt_mem   [NW];
    logic [BIAS_WIDTH-1:0] bias_mem [OUT_CHANNELS];

    assign cfg_clamped = (cfg_num_pixels > PW'(MAX_PIXELS))
                       ? PW'(MAX_PIXELS) : cfg_num_pixels;
    assign last_grp    = (grp == GW'(NG - 1));
    assign last_pix    = (pix_cnt == npix - PW'(1));
    assign out_group   = grp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (cfg_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    state_n = MAC;
                end
            end
            MAC: begin
                if (ph == 2'(MAC_CYCLES - 1)) begin
                    state_n = REQ;
                end
            end
            REQ: state_n = OUT;
            OUT: begin
                if (out_ready) begin
                    if (!last_grp) begin
                        state_n = MAC;
                    end else if (!last_pix) begin
                        state_n = FETCH;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (state)
            FETCH: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            MAC, REQ: busy = 1'b1;
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = last_grp && last_pix;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph      <= '0;
            grp     <= '0;
            npix    <= '0;
            pix_cnt <= '0;
            shift_q <= '0;
            pix_q   <= '0;
        end else begin
            ph <= (state == MAC) ? ph + 2'd1 : 2'd0;
            if (state == IDLE && start) begin
                npix    <= cfg_clamped;
                shift_q <= cfg_shift;
                pix_cnt <= '0;
            end
            if (in_valid && in_ready) begin
                pix_q <= in_data;
                grp   <= '0;
            end
            if (out_valid && out_ready) begin
                if (last_grp) begin
                    grp     <= '0;
                    pix_cnt <= pix_cnt + PW'(1);
                end else begin
                    grp <= grp + GW'(1);
                end
            end
        end
    end

    // Coefficient RAMs keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wt_wr_en && !busy && int'(wt_wr_addr) < NW) begin
            wt_mem[wt_wr_addr] <= wt_wr_data;
        end
        if (bias_wr_en && !busy && int'(bias_wr_addr) < OUT_CHANNELS) begin
            bias_mem[bias_wr_addr] <= bias_wr_data;
        end
    end

    for (genvar l = 0; l < PAR_OUT; l++) begin : g_lane
        logic [LW-1:0]         wt_q;
        logic [BIAS_WIDTH-1:0] bias_q;

        always_ff @(posedge clk) begin
            for (int i = 0; i < IN_CHANNELS; i++) begin
                wt_q[i*DATA_WIDTH +: DATA_WIDTH] <= wt_mem[
                    WAW'((int'(grp) * PAR_OUT + l) * IN_CHANNELS + i)];
            end
            bias_q <= bias_mem[BAW'(int'(grp) * PAR_OUT + l)];
        end

        conv1x1_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .IN_CHANNELS (IN_CHANNELS),
            .ACC_WIDTH   (ACC_WIDTH),
            .BIAS_WIDTH  (BIAS_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .pix    (pix_q),
            .wts    (wt_q),
            .bias   (bias_q),
            .shift  (shift_q),
            .req_en (state == REQ),
            .res    (out_data[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_conv_1x1_stream.sv
// Scoreboard bench for conv_1x1_stream with an arithmetic reference model.
module tb_conv_1x1_stream;

    localparam int DW  = 8;
    localparam int IC  = 16;
    localparam int OC  = 32;
    localparam int PO  = 4;
    localparam int MP  = 784;
    localparam int BW  = 16;
    localparam int NG  = OC / PO;
    localparam int PW  = $clog2(MP + 1);
    localparam int WAW = $clog2(IC * OC);
    localparam int BAW = $clog2(OC);
    localparam int GW  = $clog2(NG);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PW-1:0]    cfg_num_pixels;
    logic [4:0]       cfg_shift;
    logic             busy;
    logic             done;
    logic             wt_wr_en;
    logic [WAW-1:0]   wt_wr_addr;
    logic [DW-1:0]    wt_wr_data;
    logic             bias_wr_en;
    logic [BAW-1:0]   bias_wr_addr;
    logic [BW-1:0]    bias_wr_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW*IC-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW*PO-1:0] out_data;
    logic [GW-1:0]    out_group;
    logic             out_last;

    typedef struct {
        int               grp;
        logic [DW*PO-1:0] data;
        bit               last;
    } exp_t;

    exp_t sbq[$];
    int   w_m [OC][IC];
    int   b_m [OC];
    int   px_m [IC];
    int   pass_cnt  = 0;
    int   chk_cnt   = 0;
    int   done_cnt  = 0;
    bit   inr_seen  = 0;
    int   rdy_mode  = 0;
    int   ready_ctr = 0;

    always #5 clk = ~clk;

    conv_1x1_stream #(
        .DATA_WIDTH   (DW),
        .IN_CHANNELS  (IC),
        .OUT_CHANNELS (OC),
        .PAR_OUT      (PO),
        .ACC_WIDTH    (24),
        .BIAS_WIDTH   (BW),
        .MAX_PIXELS   (MP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_pixels (cfg_num_pixels),
        .cfg_shift      (cfg_shift),
        .busy           (busy),
        .done           (done),
        .wt_wr_en       (wt_wr_en),
        .wt_wr_addr     (wt_wr_addr),
        .wt_wr_data     (wt_wr_data),
        .bias_wr_en     (bias_wr_en),
        .bias_wr_addr   (bias_wr_addr),
        .bias_wr_data   (bias_wr_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_group      (out_group),
        .out_last       (out_last)
    );

    task automatic check(input string name, input longint act, input longint req);
        chk_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round half up = floor((acc + d/2) / d), then clamp to the signed output range.
    function automatic int ref_out(input int acc, input int sh);
        longint num;
        longint d;
        longint q;
        longint hi;
        hi = (longint'(1) << (DW - 1)) - 1;
        if (sh == 0) begin
            q = acc;
        end else begin
            d   = longint'(1) << sh;
            num = longint'(acc) + d / 2;
            q   = num / d;
            if ((num % d != 0) && (num < 0)) q = q - 1;
        end
        if (q > hi) q = hi;
        if (q < -hi - 1) q = -hi - 1;
`ifdef CONV1X1_RELU_EN
        if (q < 0) q = 0;
`endif
        return int'(q);
    endfunction

    function automatic int gen_w(input int mode, input int oc, input int ic);
        case (mode)
            0: return 1;
            1: return 127;
            2: return -128;
            3: return (ic < ((oc % 2 == 1) ? 5 : 6)) ? 1 : 0;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    function automatic int gen_b(input int mode);
        case (mode)
            0: return 0;
            1: return -10;
            default: return int'($urandom_range(0, 4000)) - 2000;
        endcase
    endfunction

    function automatic int gen_px(input int mode);
        case (mode)
            0: return 1;
            1: return 127;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    task automatic load(input int wmode, input int bmode);
        int w;
        int b;
        for (int a = 0; a < IC * OC; a++) begin
            w = gen_w(wmode, a / IC, a % IC);
            w_m[a / IC][a % IC] = w;
            wt_wr_en   = 1'b1;
            wt_wr_addr = WAW'(a);
            wt_wr_data = DW'(w);
            if (a < OC) begin
                b = gen_b(bmode);
                b_m[a]       = b;
                bias_wr_en   = 1'b1;
                bias_wr_addr = BAW'(a);
                bias_wr_data = BW'(b);
            end else begin
                bias_wr_en = 1'b0;
            end
            step();
        end
        wt_wr_en   = 1'b0;
        bias_wr_en = 1'b0;
    endtask

    task automatic push_expected(input int sh, input bit lastp);
        exp_t e;
        int   acc;
        int   v;
        int   oc;
        for (int g = 0; g < NG; g++) begin
            e.grp  = g;
            e.data = '0;
            e.last = lastp && (g == NG - 1);
            for (int l = 0; l < PO; l++) begin
                oc  = g * PO + l;
                acc = b_m[oc];
                for (int i = 0; i < IC; i++) acc += px_m[i] * w_m[oc][i];
                v = ref_out(acc, sh);
                e.data[l*DW +: DW] = v[DW-1:0];
            end
            sbq.push_back(e);
        end
    endtask

    task automatic feed_pixel(input int pmode, input int sh, input bit lastp);
        int n;
        for (int i = 0; i < IC; i++) begin
            px_m[i] = gen_px(pmode);
            in_data[i*DW +: DW] = DW'(px_m[i]);
        end
        push_expected(sh, lastp);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 400);
        if (!in_ready) begin
            chk_cnt++;
            $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, required 1", n);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic poke_busy();
        start          = 1'b1;
        cfg_num_pixels = PW'(1);
        wt_wr_en       = 1'b1;
        wt_wr_addr     = '0;
        wt_wr_data     = DW'(~w_m[0][0]);
        bias_wr_en     = 1'b1;
        bias_wr_addr   = '0;
        bias_wr_data   = BW'(b_m[0] + 1000);
        step();
        start      = 1'b0;
        wt_wr_en   = 1'b0;
        bias_wr_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk_cnt++;
            $display("FAIL %s: got no done within %0d cycles, required a done pulse", name, limit);
        end
        step();
        step();
    endtask

    task automatic run(input int ncfg, input int nexp, input int sh,
                       input int pmode, input bit poke);
        done_cnt       = 0;
        cfg_num_pixels = PW'(ncfg);
        cfg_shift      = 5'(sh);
        start          = 1'b1;
        step();
        start = 1'b0;
        for (int p = 0; p < nexp; p++) begin
            if (poke && p == 1) poke_busy();
            repeat ($urandom_range(0, 2)) step();
            feed_pixel(pmode, sh, p == nexp - 1);
        end
        wait_done("run_done", 2000);
        check("done_pulses", done_cnt, 1);
        check("queue_drained", sbq.size(), 0);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_group"}, out_group, 0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (ready_ctr % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ready_ctr++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) done_cnt++;
                if (in_ready) inr_seen = 1'b1;
                if (out_valid) begin
                    check("in_ready_low_while_out_valid", in_ready, 0);
                    if (sbq.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_output: got group %0d data %h, required no output",
                                 out_group, out_data);
                    end else begin
                        check("out_group", out_group, sbq[0].grp);
                        check("out_data", out_data, sbq[0].data);
                        check("out_last", out_last, sbq[0].last);
                        if (out_ready) void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        cfg_num_pixels = '0;
        cfg_shift      = '0;
        wt_wr_en       = 1'b0;
        wt_wr_addr     = '0;
        wt_wr_data     = '0;
        bias_wr_en     = 1'b0;
        bias_wr_addr   = '0;
        bias_wr_data   = '0;
        in_valid       = 1'b0;
        in_data        = '0;
        repeat (3) step();
        check_quiet("reset");
        step();
        rst = 1'b0;
        step();

        load(0, 0);
        run(1, 1, 0, 0, 0);

        load(1, 0);
        run(1, 1, 0, 1, 0);
        load(2, 0);
        run(1, 1, 0, 1, 0);

        load(3, 0);
        run(1, 1, 2, 0, 0);
        load(3, 1);
        run(1, 1, 0, 0, 0);

        load(4, 2);
        rdy_mode = 1;
        run(3, 3, int'($urandom_range(0, 10)), 2, 1);
        rdy_mode = 2;
        run(4, 4, int'($urandom_range(0, 10)), 2, 0);
        run(2, 2, 0, 2, 0);

        rdy_mode       = 0;
        inr_seen       = 1'b0;
        done_cnt       = 0;
        cfg_num_pixels = '0;
        start          = 1'b1;
        step();
        start = 1'b0;
        wait_done("zero_pixel_done", 3);
        check("zero_pixel_done_pulses", done_cnt, 1);
        check("zero_pixel_in_ready_seen", inr_seen, 0);

        done_cnt       = 0;
        cfg_num_pixels = PW'(3);
        cfg_shift      = 5'd4;
        start          = 1'b1;
        step();
        start = 1'b0;
        feed_pixel(2, 4, 1'b0);
        feed_pixel(2, 4, 1'b0);
        rst = 1'b1;
        sbq.delete();
        step();
        rst = 1'b0;
        check_quiet("mid_rst");
        repeat (10) step();
        check("mid_rst_no_done", done_cnt, 0);
        run(1, 1, 4, 2, 0);

        run(1000, MP, 3, 2, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
